// File: rtl/mem_bus_ctrl_pkg.sv
// ============================================================================
// Module : mem_bus_ctrl_pkg
// Brief  : Shared state encoding and address map for the memory bus controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam logic [31:0] BASE_LO   = 32'h8000_0000;
    localparam logic [31:0] EXT_LO    = 32'h8040_0000;
    localparam logic [31:0] RAM_HI    = 32'h8080_0000;
    localparam logic [31:0] UART_STAT = 32'hBFD0_03FC;
    localparam logic [31:0] UART_DATA = 32'hBFD0_03F8;

    function automatic logic is_base_ram(input logic [31:0] addr);
        return (addr >= BASE_LO) && (addr < EXT_LO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// Module : mem_bus_ctrl
// Brief  : Sequences CPU data accesses into multi-cycle SRAM/UART bus cycles,
//          shapes the write strobe, arbitrates BaseRAM and raises stalls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int WR_SETUP_CYC = 1,
    parameter int WR_PULSE_CYC = 1,
    parameter int WR_HOLD_CYC  = 1,
    parameter int RD_CYC       = 1,
    parameter int CNT_W        = 3
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic [31:0] if_addr_i,
    input  logic        if_ce_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        stall_req_o,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] ram2_addr_o,
    output logic [31:0] ram2_data_o,
    output logic        ram2_we_o,
    output logic [3:0]  ram2_sel_o,
    output logic        ram2_ce_o,
    input  logic [31:0] ram2_data_i
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      req_addr_q;
    logic [31:0]      req_wdata_q;
    logic [3:0]       req_sel_q;
    logic [31:0]      rdata_q;

    logic [CNT_W-1:0] w_limit;
    logic             w_last;
    logic             w_busy;

    always_comb begin
        w_limit = '0;
        case (state_q)
            ST_RD:       w_limit = CNT_W'(RD_CYC - 1);
            ST_WR_SETUP: w_limit = CNT_W'(WR_SETUP_CYC - 1);
            ST_WR_PULSE: w_limit = CNT_W'(WR_PULSE_CYC - 1);
            ST_WR_HOLD:  w_limit = CNT_W'(WR_HOLD_CYC - 1);
            default:     w_limit = '0;
        endcase
    end

    assign w_last = (cnt_q == w_limit);
    assign w_busy = (state_q == ST_RD) || (state_q == ST_WR_SETUP) ||
                    (state_q == ST_WR_PULSE) || (state_q == ST_WR_HOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mem_ce_i) begin
                    state_d = mem_we_i ? ST_WR_SETUP : ST_RD;
                end
            end
            ST_RD: begin
                if (w_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_WR_SETUP: begin
                if (w_last) begin
                    state_d = ST_WR_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_WR_PULSE: begin
                if (w_last) begin
                    state_d = ST_WR_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_WR_HOLD: begin
                if (w_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request is captured only on the IDLE exit edge; mem_* changes while busy are ignored.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_sel_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && mem_ce_i) begin
                req_addr_q  <= mem_addr_i;
                req_wdata_q <= mem_wdata_i;
                req_sel_q   <= mem_sel_i;
            end
            if (state_q == ST_RD && w_last) begin
                rdata_q <= ram2_data_i;
            end
        end
    end

    // Bus is parked outside RD/WR_* so UART strobes cannot leak past the access.
    always_comb begin
        ram2_addr_o = '0;
        ram2_data_o = '0;
        ram2_we_o   = 1'b1;
        ram2_sel_o  = 4'hF;
        ram2_ce_o   = 1'b0;
        if (w_busy) begin
            ram2_addr_o = req_addr_q;
            ram2_data_o = req_wdata_q;
            ram2_sel_o  = ~req_sel_q;
            ram2_ce_o   = 1'b1;
            ram2_we_o   = (state_q != ST_WR_PULSE);
        end
    end

    assign stall_req_o  = rst_n & (((state_q == ST_IDLE) & mem_ce_i) | w_busy);
    assign mem_rdata_o  = rdata_q;
    assign rom_addr_o   = if_addr_i;
    assign rom_ce_o     = rst_n & if_ce_i;
    assign inst_o       = rom_data_i;
    assign inst_valid_o = rst_n & if_ce_i & ~(w_busy & is_base_ram(req_addr_q));

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
// ============================================================================
// Module : tb_mem_bus_ctrl
// Brief  : Directed, table-driven bench for mem_bus_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_ctrl;

    localparam logic [31:0] C_IF_ADDR = 32'h8000_0100;
    localparam logic [31:0] C_ROM_DAT = 32'h1357_2468;

    logic        clk_50M = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] if_addr_i = C_IF_ADDR;
    logic        if_ce_i = 1'b0;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_rdata_o;
    logic        stall_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] rom_data_i = C_ROM_DAT;
    logic [31:0] ram2_addr_o;
    logic [31:0] ram2_data_o;
    logic        ram2_we_o;
    logic [3:0]  ram2_sel_o;
    logic        ram2_ce_o;
    logic [31:0] ram2_data_i = '0;

    int errors = 0;
    int checks = 0;

    always #10 clk_50M = ~clk_50M;

    mem_bus_ctrl dut (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .if_addr_i    (if_addr_i),
        .if_ce_i      (if_ce_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .mem_ce_i     (mem_ce_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_sel_i    (mem_sel_i),
        .mem_rdata_o  (mem_rdata_o),
        .stall_req_o  (stall_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_ce_o     (rom_ce_o),
        .rom_data_i   (rom_data_i),
        .ram2_addr_o  (ram2_addr_o),
        .ram2_data_o  (ram2_data_o),
        .ram2_we_o    (ram2_we_o),
        .ram2_sel_o   (ram2_sel_o),
        .ram2_ce_o    (ram2_ce_o),
        .ram2_data_i  (ram2_data_i)
    );

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        ifce;
        logic [31:0] rdin;
        logic        stall;
        logic        bwe;
        logic        bce;
        logic [31:0] baddr;
        logic [31:0] bdata;
        logic [3:0]  bsel;
        logic        ivld;
        logic [31:0] rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic ce, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] sel, input logic ifce, input logic [31:0] rdin,
        input logic stall, input logic bwe, input logic bce, input logic [31:0] baddr,
        input logic [31:0] bdata, input logic [3:0] bsel, input logic ivld, input logic [31:0] rdata);
        vec_t v;
        v.ce = ce; v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel; v.ifce = ifce;
        v.rdin = rdin; v.stall = stall; v.bwe = bwe; v.bce = bce; v.baddr = baddr;
        v.bdata = bdata; v.bsel = bsel; v.ivld = ivld; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, " we"},   32'(ram2_we_o),   32'h1);
        chk({tag, " ce"},   32'(ram2_ce_o),   32'h0);
        chk({tag, " addr"}, ram2_addr_o,      32'h0);
    endtask

    task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel, input logic ifce,
                         input logic [31:0] rdin);
        mem_ce_i = ce; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata;
        mem_sel_i = sel; if_ce_i = ifce; ram2_data_i = rdin;
    endtask

    initial begin
        // load 0x80400010 -> DEADBEEF
        vq.push_back(mk(1,0,32'h80400010,0,4'hF,1,32'hDEADBEEF, 1,1,0,0,0,4'hF,1,0));
        vq.push_back(mk(1,0,32'h80400010,0,4'hF,1,32'hDEADBEEF, 1,1,1,32'h80400010,0,4'h0,1,0));
        vq.push_back(mk(0,0,0,0,4'h0,1,0, 0,1,0,0,0,4'hF,1,32'hDEADBEEF));
        // store 0x12345678 to 0x80400020, sel 0011
        vq.push_back(mk(1,1,32'h80400020,32'h12345678,4'h3,1,0, 1,1,0,0,0,4'hF,1,32'hDEADBEEF));
        vq.push_back(mk(1,1,32'h80400020,32'h12345678,4'h3,1,0, 1,1,1,32'h80400020,32'h12345678,4'hC,1,32'hDEADBEEF));
        vq.push_back(mk(1,1,32'h80400020,32'h12345678,4'h3,1,0, 1,0,1,32'h80400020,32'h12345678,4'hC,1,32'hDEADBEEF));
        vq.push_back(mk(1,1,32'h80400020,32'h12345678,4'h3,1,0, 1,1,1,32'h80400020,32'h12345678,4'hC,1,32'hDEADBEEF));
        vq.push_back(mk(0,0,0,0,4'h0,1,0, 0,1,0,0,0,4'hF,1,32'hDEADBEEF));
        // UART data store 0x41
        vq.push_back(mk(1,1,32'hBFD003F8,32'h41,4'h1,1,0, 1,1,0,0,0,4'hF,1,32'hDEADBEEF));
        vq.push_back(mk(1,1,32'hBFD003F8,32'h41,4'h1,1,0, 1,1,1,32'hBFD003F8,32'h41,4'hE,1,32'hDEADBEEF));
        vq.push_back(mk(1,1,32'hBFD003F8,32'h41,4'h1,1,0, 1,0,1,32'hBFD003F8,32'h41,4'hE,1,32'hDEADBEEF));
        vq.push_back(mk(1,1,32'hBFD003F8,32'h41,4'h1,1,0, 1,1,1,32'hBFD003F8,32'h41,4'hE,1,32'hDEADBEEF));
        vq.push_back(mk(0,0,0,0,4'h0,1,0, 0,1,0,0,0,4'hF,1,32'hDEADBEEF));
        vq.push_back(mk(0,0,0,0,4'h0,1,0, 0,1,0,0,0,4'hF,1,32'hDEADBEEF));
        // BaseRAM load blocks fetch; ExtRAM load does not
        vq.push_back(mk(1,0,32'h80001000,0,4'hF,1,32'hCAFEF00D, 1,1,0,0,0,4'hF,1,32'hDEADBEEF));
        vq.push_back(mk(1,0,32'h80001000,0,4'hF,1,32'hCAFEF00D, 1,1,1,32'h80001000,0,4'h0,0,32'hDEADBEEF));
        vq.push_back(mk(0,0,0,0,4'h0,1,0, 0,1,0,0,0,4'hF,1,32'hCAFEF00D));
        vq.push_back(mk(1,0,32'h80400000,0,4'hF,1,32'h11112222, 1,1,0,0,0,4'hF,1,32'hCAFEF00D));
        vq.push_back(mk(1,0,32'h80400000,0,4'hF,1,32'h11112222, 1,1,1,32'h80400000,0,4'h0,1,32'hCAFEF00D));
        vq.push_back(mk(0,0,0,0,4'h0,1,0, 0,1,0,0,0,4'hF,1,32'h11112222));
        // back-to-back load then store; request shown in DONE must not start
        vq.push_back(mk(1,0,32'h80400004,0,4'hF,1,32'h0A0B0C0D, 1,1,0,0,0,4'hF,1,32'h11112222));
        vq.push_back(mk(1,0,32'h80400004,0,4'hF,1,32'h0A0B0C0D, 1,1,1,32'h80400004,0,4'h0,1,32'h11112222));
        vq.push_back(mk(1,1,32'h80400008,32'h55,4'hF,1,32'hFFFFFFFF, 0,1,0,0,0,4'hF,1,32'h0A0B0C0D));
        vq.push_back(mk(1,1,32'h80400008,32'h55,4'hF,1,32'hFFFFFFFF, 1,1,0,0,0,4'hF,1,32'h0A0B0C0D));
        vq.push_back(mk(1,1,32'h80400008,32'h55,4'hF,1,32'hFFFFFFFF, 1,1,1,32'h80400008,32'h55,4'h0,1,32'h0A0B0C0D));
        vq.push_back(mk(1,1,0,0,4'h0,1,32'hFFFFFFFF, 1,0,1,32'h80400008,32'h55,4'h0,1,32'h0A0B0C0D));
        vq.push_back(mk(1,1,32'h80400008,32'h55,4'hF,1,32'hFFFFFFFF, 1,1,1,32'h80400008,32'h55,4'h0,1,32'h0A0B0C0D));
        vq.push_back(mk(0,0,0,0,4'h0,1,32'hFFFFFFFF, 0,1,0,0,0,4'hF,1,32'h0A0B0C0D));
        vq.push_back(mk(0,0,0,0,4'h0,0,0, 0,1,0,0,0,4'hF,0,32'h0A0B0C0D));
        // BaseRAM store also blocks fetch through every write phase
        vq.push_back(mk(1,1,32'h80000010,32'hAA,4'hF,1,0, 1,1,0,0,0,4'hF,1,32'h0A0B0C0D));
        vq.push_back(mk(1,1,32'h80000010,32'hAA,4'hF,1,0, 1,1,1,32'h80000010,32'hAA,4'h0,0,32'h0A0B0C0D));
        vq.push_back(mk(1,1,32'h80000010,32'hAA,4'hF,1,0, 1,0,1,32'h80000010,32'hAA,4'h0,0,32'h0A0B0C0D));
        vq.push_back(mk(1,1,32'h80000010,32'hAA,4'hF,1,0, 1,1,1,32'h80000010,32'hAA,4'h0,0,32'h0A0B0C0D));
        vq.push_back(mk(0,0,0,0,4'h0,1,0, 0,1,0,0,0,4'hF,1,32'h0A0B0C0D));

        // reset state, with a pending request visible on the inputs
        drive(1, 1, 32'h80400000, 32'h1, 4'hF, 1, 0);
        repeat (2) @(posedge clk_50M);
        @(negedge clk_50M);
        chk("rst stall",  32'(stall_req_o),  32'h0);
        chk("rst sel",    32'(ram2_sel_o),   32'hF);
        chk("rst data",   ram2_data_o,       32'h0);
        chk("rst rdata",  mem_rdata_o,       32'h0);
        chk("rst romce",  32'(rom_ce_o),     32'h0);
        chk("rst ivld",   32'(inst_valid_o), 32'h0);
        chk_idle_bus("rst");
        drive(0, 0, 0, 0, 4'h0, 1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk_50M);
            #1;
            drive(vq[i].ce, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].sel, vq[i].ifce, vq[i].rdin);
            @(negedge clk_50M);
            chk($sformatf("v%0d stall", i), 32'(stall_req_o),  32'(vq[i].stall));
            chk($sformatf("v%0d we", i),    32'(ram2_we_o),    32'(vq[i].bwe));
            chk($sformatf("v%0d ce", i),    32'(ram2_ce_o),    32'(vq[i].bce));
            chk($sformatf("v%0d addr", i),  ram2_addr_o,       vq[i].baddr);
            chk($sformatf("v%0d data", i),  ram2_data_o,       vq[i].bdata);
            chk($sformatf("v%0d sel", i),   32'(ram2_sel_o),   32'(vq[i].bsel));
            chk($sformatf("v%0d ivld", i),  32'(inst_valid_o), 32'(vq[i].ivld));
            chk($sformatf("v%0d rdata", i), mem_rdata_o,       vq[i].rdata);
            chk($sformatf("v%0d romce", i), 32'(rom_ce_o),     32'(vq[i].ifce));
            chk($sformatf("v%0d romaddr", i), rom_addr_o,      C_IF_ADDR);
            chk($sformatf("v%0d inst", i),  inst_o,            C_ROM_DAT);
        end

        // reset asserted in the middle of WR_PULSE
        @(posedge clk_50M);
        #1;
        drive(1, 1, 32'h80400030, 32'h77, 4'hF, 1, 0);
        @(posedge clk_50M);
        @(posedge clk_50M);
        @(negedge clk_50M);
        chk("pulse we", 32'(ram2_we_o), 32'h0);
        #4;
        rst_n = 1'b0;
        #1;
        chk("arst we",    32'(ram2_we_o),   32'h1);
        chk("arst stall", 32'(stall_req_o), 32'h0);
        chk("arst ce",    32'(ram2_ce_o),   32'h0);
        chk("arst rdata", mem_rdata_o,      32'h0);
        @(posedge clk_50M);
        @(negedge clk_50M);
        drive(0, 0, 0, 0, 4'h0, 1, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_50M);
            #1;
            @(negedge clk_50M);
            chk($sformatf("post%0d stall", k), 32'(stall_req_o), 32'h0);
            chk_idle_bus($sformatf("post%0d", k));
        end

        // controller resumes from IDLE after release
        @(posedge clk_50M);
        #1;
        drive(1, 0, 32'h80400040, 0, 4'hF, 1, 32'h13579BDF);
        @(negedge clk_50M);
        chk("rel idle stall", 32'(stall_req_o), 32'h1);
        chk("rel idle ce",    32'(ram2_ce_o),   32'h0);
        @(posedge clk_50M);
        @(negedge clk_50M);
        chk("rel rd ce",   32'(ram2_ce_o), 32'h1);
        chk("rel rd addr", ram2_addr_o,    32'h80400040);
        @(posedge clk_50M);
        #1;
        drive(0, 0, 0, 0, 4'h0, 1, 0);
        @(negedge clk_50M);
        chk("rel done stall", 32'(stall_req_o), 32'h0);
        chk("rel done rdata", mem_rdata_o,      32'h13579BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
